// File: rtl/chart_decimator_pkg.sv
// Shared graphics definitions: reduction modes, decimator FSM states, config record.
// Also consumed by the chart renderer register map, so encodings are fixed.
// Pure declarations; no logic.
package chart_decimator_pkg;

  // Reduction selection applied to each decimation group
  typedef logic [1:0] mode_t;
  localparam mode_t MODE_MAX   = 2'd0;
  localparam mode_t MODE_MIN   = 2'd1;
  localparam mode_t MODE_FIRST = 2'd2;
  localparam mode_t MODE_MEAN  = 2'd3;

  // Decimator FSM: no group open / group partially accumulated
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACC  = 1'b1;

  // Configuration captured at frame start
  typedef struct packed {
    logic [2:0] shift;
    mode_t      mode;
  } cfg_t;

  // Limit a requested shift to the largest ratio the datapath supports
  function automatic logic [2:0] clamp_shift(input logic [2:0] shift, input logic [2:0] shift_max);
    return (shift > shift_max) ? shift_max : shift;
  endfunction

endpackage

// File: rtl/chart_decimator_if.sv
// Sample stream bundle (data, frame start/end markers, valid/ready).
// Master drives payload and valid, slave drives ready.
// No logic; a transfer happens when valid and ready are both high.
interface chart_decimator_if #(
  parameter int DATA_W = 16
) ();
  logic [DATA_W-1:0] tdata;
  logic              tlast;
  logic              tuser;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tlast, output tuser, output tvalid, input tready);
  modport slave  (input tdata, input tlast, input tuser, input tvalid, output tready);
endinterface

// File: rtl/chart_decimator_reduce.sv
// Group reduction datapath: running max/min/first/sum plus mode-selected result.
// Result is combinational from the accumulators and the sample being taken.
// No flow control of its own; registers advance only when take_i is high.
module decim_reduce
  import chart_decimator_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int SHIFT_MAX = 7
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              take_i,
  input  logic              fresh_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [2:0]        shift_i,
  input  mode_t             mode_i,
  output logic [DATA_W-1:0] result_o
);

  // Wide enough that 2^SHIFT_MAX full-scale samples never overflow
  localparam int SUM_W = DATA_W + SHIFT_MAX;

  logic [DATA_W-1:0] max_q, max_d;
  logic [DATA_W-1:0] min_q, min_d;
  logic [DATA_W-1:0] first_q, first_d;
  logic [SUM_W-1:0]  sum_q, sum_d;

  // Fold the incoming sample into the group, or restart the group with it
  always_comb begin
    max_d   = max_q;
    min_d   = min_q;
    first_d = first_q;
    sum_d   = sum_q;
    if (fresh_i) begin
      max_d   = data_i;
      min_d   = data_i;
      first_d = data_i;
      sum_d   = SUM_W'(data_i);
    end else begin
      max_d = (data_i > max_q) ? data_i : max_q;
      min_d = (data_i < min_q) ? data_i : min_q;
      sum_d = sum_q + SUM_W'(data_i);
    end
  end

  // Mean always divides by the nominal ratio, even for a short final group
  always_comb begin
    result_o = max_d;
    case (mode_i)
      MODE_MAX:   result_o = max_d;
      MODE_MIN:   result_o = min_d;
      MODE_FIRST: result_o = first_d;
      MODE_MEAN:  result_o = DATA_W'(sum_d >> shift_i);
      default:    result_o = max_d;
    endcase
  end

  // Accumulators advance on every accepted sample
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      max_q   <= '0;
      min_q   <= '0;
      first_q <= '0;
      sum_q   <= '0;
    end else if (take_i) begin
      max_q   <= max_d;
      min_q   <= min_d;
      first_q <= first_d;
      sum_q   <= sum_d;
    end
  end

endmodule

// File: rtl/chart_decimator.sv
// Chart decimator: reduces each group of 2^shift samples to one output sample.
// Latency: 1 clk from the group-closing sample to tvalid on the output.
// Backpressure: upstream ready only when the single output register is free or draining.
module chart_decimator
  import chart_decimator_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int SHIFT_MAX = 7
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ce,
  input  logic [2:0]        cfg_shift,
  input  mode_t             cfg_mode,
  chart_decimator_if.slave  up_if,
  chart_decimator_if.master dn_if
);

  // Count must reach the full ratio 2^SHIFT_MAX
  localparam int CNT_W = SHIFT_MAX + 1;

  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  count_inc;
  logic [CNT_W-1:0]  ratio;
  cfg_t              cfg_q, cfg_eff;
  logic              started_q, started_d;
  logic              grp_user_q, grp_user_d;
  logic              out_vld_q, out_vld_d;
  logic [DATA_W-1:0] out_dat_q, out_dat_d;
  logic              out_last_q, out_last_d;
  logic              out_user_q, out_user_d;
  logic [DATA_W-1:0] result;
  logic              accept;
  logic              latch_cfg;
  logic              fresh;
  logic              complete;

  // Ready never looks at upstream valid, so no combinational loop through the source
  assign up_if.tready = ce & (~out_vld_q | dn_if.tready);
  assign accept       = up_if.tvalid & up_if.tready;

  // Config is sampled at frame start only, except before the very first frame
  assign latch_cfg = accept & (((state_q == ST_IDLE) & up_if.tuser) | ~started_q);

  // The sample that latches config is processed with the new config
  always_comb begin
    cfg_eff = cfg_q;
    if (latch_cfg) begin
      cfg_eff.shift = clamp_shift(cfg_shift, 3'(SHIFT_MAX));
      cfg_eff.mode  = cfg_mode;
    end
  end

  assign ratio     = CNT_W'(1) << cfg_eff.shift;
  // A frame start mid-group abandons the open group and reopens with this sample
  assign fresh     = (state_q == ST_IDLE) | up_if.tuser;
  assign count_inc = fresh ? CNT_W'(1) : count_q + CNT_W'(1);
  assign complete  = accept & ((count_inc == ratio) | up_if.tlast);

  decim_reduce #(
    .DATA_W    (DATA_W),
    .SHIFT_MAX (SHIFT_MAX)
  ) u_reduce (
    .clk      (clk),
    .reset_n  (reset_n),
    .take_i   (accept),
    .fresh_i  (fresh),
    .data_i   (up_if.tdata),
    .shift_i  (cfg_eff.shift),
    .mode_i   (cfg_eff.mode),
    .result_o (result)
  );

  // Group tracking: open on a fresh sample, close on full count or end of frame
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    grp_user_d = grp_user_q;
    started_d  = started_q | (accept & up_if.tuser);
    if (accept) begin
      if (fresh) grp_user_d = up_if.tuser;
      if (complete) begin
        state_d = ST_IDLE;
        count_d = '0;
      end else begin
        state_d = ST_ACC;
        count_d = count_inc;
      end
    end
  end

  // Output register: load on group close, otherwise drain when downstream takes it
  always_comb begin
    out_vld_d  = out_vld_q;
    out_dat_d  = out_dat_q;
    out_last_d = out_last_q;
    out_user_d = out_user_q;
    if (complete) begin
      out_vld_d  = 1'b1;
      out_dat_d  = result;
      out_last_d = up_if.tlast;
      out_user_d = fresh ? up_if.tuser : grp_user_q;
    end else if (ce & dn_if.tready) begin
      out_vld_d = 1'b0;
    end
  end

  // Group-tracking state; everything stalls with ce because accept includes ce
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      cfg_q      <= '0;
      started_q  <= 1'b0;
      grp_user_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      cfg_q      <= cfg_eff;
      started_q  <= started_d;
      grp_user_q <= grp_user_d;
    end
  end

  // Output holding register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_vld_q  <= 1'b0;
      out_dat_q  <= '0;
      out_last_q <= 1'b0;
      out_user_q <= 1'b0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_dat_q  <= out_dat_d;
      out_last_q <= out_last_d;
      out_user_q <= out_user_d;
    end
  end

  assign dn_if.tvalid = out_vld_q;
  assign dn_if.tdata  = out_dat_q;
  assign dn_if.tlast  = out_last_q;
  assign dn_if.tuser  = out_user_q;

endmodule

// File: tb/tb_chart_decimator.sv
// Directed bench for chart_decimator with a queue-based group model and literal checks.
module tb_chart_decimator;

  localparam int DW   = 16;
  localparam int SMAX = 7;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ce;
  logic [2:0] cfg_shift;
  logic [1:0] cfg_mode;

  chart_decimator_if #(.DATA_W(DW)) up ();
  chart_decimator_if #(.DATA_W(DW)) dn ();

  chart_decimator #(.DATA_W(DW), .SHIFT_MAX(SMAX)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ce        (ce),
    .cfg_shift (cfg_shift),
    .cfg_mode  (cfg_mode),
    .up_if     (up),
    .dn_if     (dn)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
    logic          u;
  } ob_t;
  ob_t obs[$];

  // Model state
  int   grp[$];
  bit   started;
  int   m_shift;
  int   m_mode;
  bit   g_user;
  bit   exp_vld;
  int   exp_dat;
  bit   exp_last;
  bit   exp_user;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    grp.delete();
    started  = 0;
    m_shift  = 0;
    m_mode   = 0;
    g_user   = 0;
    exp_vld  = 0;
    exp_dat  = 0;
    exp_last = 0;
    exp_user = 0;
  endtask

  // Group-level model: collect samples, reduce when the group closes
  task automatic model_accept(input int d, input bit u, input bit l);
    bit idle;
    int mx, mn, sm, r;
    idle = (grp.size() == 0);
    if (u && !idle) grp.delete();
    if ((idle && u) || !started) begin
      m_shift = (int'(cfg_shift) > SMAX) ? SMAX : int'(cfg_shift);
      m_mode  = int'(cfg_mode);
    end
    if (u) started = 1;
    if (grp.size() == 0) g_user = u;
    grp.push_back(d);
    if (grp.size() == (1 << m_shift) || l) begin
      mx = grp[0];
      mn = grp[0];
      sm = 0;
      foreach (grp[i]) begin
        if (grp[i] > mx) mx = grp[i];
        if (grp[i] < mn) mn = grp[i];
        sm += grp[i];
      end
      case (m_mode)
        0:       r = mx;
        1:       r = mn;
        2:       r = grp[0];
        default: r = (sm >> m_shift) & 16'hFFFF;
      endcase
      exp_vld  = 1;
      exp_dat  = r;
      exp_last = l;
      exp_user = g_user;
      grp.delete();
    end
  endtask

  // Per-cycle compare against the model, then advance the model for the coming edge
  initial begin
    bit acc, pop, exp_rdy;
    model_reset();
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        model_reset();
        chk("rst_tvalid_m", 32'(dn.tvalid), 0);
        chk("rst_tdata_m", 32'(dn.tdata), 0);
        chk("rst_tlast_m", 32'(dn.tlast), 0);
        chk("rst_tuser_m", 32'(dn.tuser), 0);
      end else begin
        exp_rdy = ce && (!exp_vld || dn.tready);
        chk("tready_s", 32'(up.tready), 32'(exp_rdy));
        chk("tvalid_m", 32'(dn.tvalid), 32'(exp_vld));
        if (exp_vld) begin
          chk("tdata_m", 32'(dn.tdata), 32'(exp_dat));
          chk("tlast_m", 32'(dn.tlast), 32'(exp_last));
          chk("tuser_m", 32'(dn.tuser), 32'(exp_user));
        end
        acc = up.tvalid && exp_rdy;
        pop = exp_vld && dn.tready && ce;
        if (pop) begin
          obs.push_back('{d: dn.tdata, l: dn.tlast, u: dn.tuser});
          exp_vld = 0;
        end
        if (acc) model_accept(int'(up.tdata), up.tuser, up.tlast);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input bit u, input bit l);
    bit done;
    done = 0;
    up.tdata  = DW'(d);
    up.tuser  = u;
    up.tlast  = l;
    up.tvalid = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      done = up.tvalid && up.tready && ce;
      @(posedge clk);
      #1;
    end
    up.tvalid = 1'b0;
    up.tuser  = 1'b0;
    up.tlast  = 1'b0;
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: sample %0d never accepted", d);
    end
  endtask

  task automatic chk_obs(input string nm, input int idx, input int d, input bit l, input bit u);
    if (idx < obs.size()) begin
      chk({nm, "_data"}, 32'(obs[idx].d), 32'(d));
      chk({nm, "_last"}, 32'(obs[idx].l), 32'(l));
      chk({nm, "_user"}, 32'(obs[idx].u), 32'(u));
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    ce        = 1'b1;
    cfg_shift = 3'd2;
    cfg_mode  = 2'd0;
    up.tdata  = '0;
    up.tuser  = 1'b0;
    up.tlast  = 1'b0;
    up.tvalid = 1'b0;
    dn.tready = 1'b1;
    idle(3);
    reset_n = 1'b1;
    idle(1);
    chk("post_rst_tready_s", 32'(up.tready), 1);

    // Max over a full group of 4; result visible one clock after the closing sample
    obs.delete();
    send(5, 1, 0);
    send(9, 0, 0);
    send(3, 0, 0);
    send(7, 0, 0);
    chk("max_lat_tvalid", 32'(dn.tvalid), 1);
    chk("max_lat_tdata", 32'(dn.tdata), 9);
    chk("max_lat_tuser", 32'(dn.tuser), 1);
    idle(3);
    chk("max_count", 32'(obs.size()), 1);

    // Mean with a short final group still divides by 4
    obs.delete();
    cfg_mode = 2'd3;
    send(10, 1, 0);
    send(20, 0, 0);
    send(30, 0, 0);
    send(41, 0, 0);
    send(1, 0, 0);
    send(2, 0, 1);
    idle(3);
    chk("mean_count", 32'(obs.size()), 2);
    chk_obs("mean0", 0, 25, 0, 1);
    chk_obs("mean1", 1, 0, 1, 0);

    // Ratio 1 min with a 5-cycle downstream stall
    obs.delete();
    cfg_shift = 3'd0;
    cfg_mode  = 2'd1;
    dn.tready = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) send(100 + i, i == 0, 0);
      end
      begin
        repeat (2) @(posedge clk);
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("stall_tready_s", 32'(up.tready), 0);
          chk("stall_tdata_m", 32'(dn.tdata), 100);
        end
        @(posedge clk);
        #1;
        dn.tready = 1'b1;
      end
    join
    idle(3);
    chk("stall_count", 32'(obs.size()), 10);
    for (int i = 0; i < 10; i++) chk_obs("stall", i, 100 + i, 0, i == 0);

    // First-sample mode; a frame start mid-group drops the three samples before it
    obs.delete();
    cfg_shift = 3'd3;
    cfg_mode  = 2'd2;
    send(50, 1, 0);
    send(51, 0, 0);
    send(52, 0, 0);
    for (int i = 0; i < 8; i++) send(60 + i, i == 0, 0);
    idle(3);
    chk("discard_count", 32'(obs.size()), 1);
    chk_obs("discard", 0, 60, 0, 1);

    // Clock enable low freezes a pending output even with downstream ready
    obs.delete();
    dn.tready = 1'b0;
    send(70, 1, 1);
    ce        = 1'b0;
    dn.tready = 1'b1;
    idle(3);
    chk("ce_hold_tvalid", 32'(dn.tvalid), 1);
    chk("ce_hold_count", 32'(obs.size()), 0);
    ce = 1'b1;
    idle(2);
    chk("ce_count", 32'(obs.size()), 1);
    chk_obs("ce", 0, 70, 1, 1);

    // Mid-frame shift change is ignored until the next frame start
    obs.delete();
    cfg_shift = 3'd2;
    cfg_mode  = 2'd0;
    send(1, 1, 0);
    cfg_shift = 3'd1;
    for (int i = 2; i <= 8; i++) send(i, 0, 0);
    send(20, 1, 0);
    send(21, 0, 0);
    idle(3);
    chk("cfg_count", 32'(obs.size()), 3);
    chk_obs("cfg0", 0, 4, 0, 1);
    chk_obs("cfg1", 1, 8, 0, 0);
    chk_obs("cfg2", 2, 21, 0, 1);

    // Reset with a group open: the partial group must not leak into later output
    obs.delete();
    cfg_shift = 3'd2;
    send(44, 1, 0);
    send(45, 0, 0);
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    idle(1);
    for (int i = 0; i < 4; i++) send(50 + i, 0, 0);
    idle(3);
    chk("rst_grp_count", 32'(obs.size()), 1);
    chk_obs("rst_grp", 0, 53, 0, 0);

    // Reset with an output pending clears valid at once
    dn.tready = 1'b0;
    for (int i = 0; i < 4; i++) send(60 + i, i == 0, 0);
    idle(1);
    chk("pend_tvalid", 32'(dn.tvalid), 1);
    reset_n = 1'b0;
    #1;
    chk("rst_now_tvalid", 32'(dn.tvalid), 0);
    chk("rst_now_tdata", 32'(dn.tdata), 0);
    idle(2);
    reset_n   = 1'b1;
    dn.tready = 1'b1;
    idle(3);
    chk("rst_after_tvalid", 32'(dn.tvalid), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/chart_decimator.md
CHART_DECIMATOR -- requirements
Module: chart_decimator

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample width in bits (unsigned samples).
REQ-002 SHALL have parameter SHIFT_MAX, default 7, largest accepted cfg_shift (ratio up to 128).
REQ-003 clk  input  1  clock; all logic on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 ce  input  1  clock enable; when low, all state holds.
REQ-006 tdata_s / tlast_s / tuser_s / tvalid_s  input  DATA_W/1/1/1  upstream sample stream; tuser_s marks the first sample of a frame, tlast_s marks the last.
REQ-007 tready_s  output  1  upstream ready.
REQ-008 tdata_m / tlast_m / tuser_m / tvalid_m  output  DATA_W/1/1/1  decimated stream to the chart renderer.
REQ-009 tready_m  input  1  downstream ready.
REQ-010 cfg_shift  input  3  decimation ratio = 2^cfg_shift; values above SHIFT_MAX clamp to SHIFT_MAX.
REQ-011 cfg_mode  input  2  reduction: 0 max, 1 min, 2 first sample, 3 mean.

Function
REQ-012 tready_s SHALL equal ce AND (NOT tvalid_m OR tready_m); it SHALL NOT depend on tvalid_s.
REQ-013 A sample is accepted on a clk edge where tvalid_s, tready_s and ce are all high.
REQ-014 An FSM SHALL have two states: IDLE (no open group) and ACC (group open, count = samples taken, 1..ratio-1).
REQ-015 In IDLE, an accepted sample SHALL load the accumulator (max=min=first=sum=tdata_s), set count=1 and enter ACC, unless it also completes the group (ratio 1 or tlast_s).
REQ-016 In ACC, an accepted sample SHALL update max (unsigned >), min (unsigned <), sum (+) and count; first is held.
REQ-017 A group SHALL complete on the accepted sample that brings count to ratio, or on any accepted sample with tlast_s=1; the FSM then returns to IDLE.
REQ-018 On completion, the output register SHALL load the mode-selected result with a latency of 1 clk, with tvalid_m asserting on the next edge.
REQ-019 The sum SHALL be DATA_W+SHIFT_MAX bits, never overflowing; mean = sum >> cfg_shift, truncated to DATA_W.
REQ-020 A partial group (tlast_s before ratio) in mean mode SHALL still shift by cfg_shift; max/min/first are exact.
REQ-021 tlast_m SHALL be 1 on the output produced by a group that closed on tlast_s.
REQ-022 tuser_m SHALL be 1 on the first output of each frame, i.e. the output from the group opened by a sample with tuser_s=1.
REQ-023 tuser_s accepted while in ACC SHALL discard the open group (no output) and start a new group with that sample.
REQ-024 cfg_shift and cfg_mode SHALL be latched only when a sample is accepted in IDLE with tuser_s=1, or when no frame has started since reset; mid-frame changes are ignored.
REQ-025 The output register SHALL hold tdata_m/tlast_m/tuser_m stable while tvalid_m=1 and tready_m=0.
REQ-026 tvalid_m SHALL clear on the edge where tready_m=1 and no new result is loaded; a simultaneous pop and load keeps tvalid_m=1 with the new data.
REQ-027 While ce=0: tready_s=0, the FSM, accumulators and output register hold, and tvalid_m stays as is.

Reset
REQ-028 On reset_n low: tvalid_m=0, tdata_m=0, tlast_m=0, tuser_m=0, FSM=IDLE, count=0, accumulators=0, latched cfg = shift 0 / mode 0.
REQ-029 Reset mid-group SHALL drop the partial group without emitting; the first post-reset output comes from fresh samples only.

Structure
REQ-030 Mode encodings (MODE_MAX/MIN/FIRST/MEAN) and FSM state encodings SHALL live in a shared graphics package, also used by the chart renderer's register map.
REQ-031 A single sub-module, decim_reduce, SHALL hold the max/min/first/sum datapath; the FSM, handshake and output register stay in chart_decimator.

Verification
REQ-032 shift=2, mode 0, samples 5,9,3,7 (tuser on 5) with tready_m=1 -> one output 9, tuser_m=1, 1 clk after 7 is accepted.
REQ-033 shift=2, mode 3, samples 10,20,30,41,1,2 (tlast on 2) -> outputs 25, then 0 (sum 3>>2) with tlast_m=1.
REQ-034 shift=0, mode 1, continuous stream, tready_m held 0 for 5 cycles -> tready_s=0, tdata_m stable, no samples lost after release.
REQ-035 shift=3, mode 2, tuser_s on the 4th sample of a group -> first 3 samples discarded, next output = 4th sample value, tuser_m=1.
REQ-036 cfg_shift changed 2->1 mid-frame -> grouping stays 4 until next tuser_s; reset asserted mid-group -> tvalid_m=0 immediately, no stale output.
